// File: rtl/mp_final_reduce_pkg.sv
// Shared widths and state encoding for the conditional final-subtraction stage.
package mp_final_reduce_pkg;

   localparam int OP_W    = 1027;
   localparam int CHUNK_W = 257;
   localparam int NCHUNK  = (OP_W + 1) / CHUNK_W;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SUB  = 2'd1,
      SEL  = 2'd2,
      DONE = 2'd3
   } state_t;

endpackage

// File: rtl/mp_final_reduce_chunk_sub.sv
// One word slice of the subtract chain: {cout, diff} = a + ~b + cin.
module mp_final_reduce_chunk_sub #(
   parameter int W = 257
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         cin,
   output logic [W-1:0] diff,
   output logic         cout
);

   logic [W:0] sum;

   // NOTE: ~b sits inside a concatenation so it is inverted at W bits; in a
   // wider context it would be zero-extended first and the top bit would flip to 1.
   assign sum  = {1'b0, a} + {1'b0, ~b} + {{W{1'b0}}, cin};
   assign diff = sum[W-1:0];
   assign cout = sum[W];

endmodule

// File: rtl/mp_final_reduce.sv
// Final conditional subtraction: returns T mod M for T < 2M, subtracting one
// CHUNK_W-bit slice per cycle through a single registered borrow.
module mp_final_reduce
   import mp_final_reduce_pkg::*;
(
   input  logic            clk,
   input  logic            resetn,
   input  logic            start,
   input  logic [OP_W:0]   in_t,
   input  logic [OP_W-1:0] in_m,
   output logic [OP_W-1:0] result,
   output logic            reduced,
   output logic            busy,
   output logic            done
);

   state_t              state, state_nxt;
   logic [OP_W:0]       t_sh, m_sh, d_sh;
   logic [OP_W-1:0]     t_keep;
   logic                carry;
   logic [1:0]          cnt;
   logic [CHUNK_W-1:0]  s_diff;
   logic                s_cout;
   logic                load;

   assign load = start && (state == IDLE || state == DONE);
   assign busy = (state == SUB) || (state == SEL);

   mp_final_reduce_chunk_sub #(.W(CHUNK_W)) u_chunk_sub (
      .a    (t_sh[CHUNK_W-1:0]),
      .b    (m_sh[CHUNK_W-1:0]),
      .cin  (carry),
      .diff (s_diff),
      .cout (s_cout)
   );

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values of the others.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) state <= IDLE;
      else         state <= state_nxt;
   end

   // NOTE: next state defaults to the current state first so no path leaves
   // state_nxt unassigned, which would otherwise infer a latch.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (start) state_nxt = SUB;
         SUB:  if (cnt == 2'(NCHUNK - 1)) state_nxt = SEL;
         SEL:  state_nxt = DONE;
         DONE: state_nxt = start ? SUB : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         t_sh    <= '0;
         m_sh    <= '0;
         d_sh    <= '0;
         t_keep  <= '0;
         carry   <= 1'b0;
         cnt     <= 2'd0;
         result  <= '0;
         reduced <= 1'b0;
         done    <= 1'b0;
      end else begin
         done <= 1'b0;
         if (load) begin
            t_sh   <= in_t;
            t_keep <= in_t[OP_W-1:0];
            m_sh   <= {1'b0, in_m};
            carry  <= 1'b1;   // +1 of the two's-complement negation of M
            cnt    <= 2'd0;
         end else if (state == SUB) begin
            d_sh  <= {s_diff, d_sh[OP_W:CHUNK_W]};
            t_sh  <= t_sh >> CHUNK_W;
            m_sh  <= m_sh >> CHUNK_W;
            carry <= s_cout;
            cnt   <= cnt + 2'd1;
         end else if (state == SEL) begin
            // Final carry set means no borrow out, i.e. T >= M.
            result  <= carry ? d_sh[OP_W-1:0] : t_keep;
            reduced <= carry;
            done    <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_mp_final_reduce.sv
// Self-checking bench for mp_final_reduce against an arithmetic T mod M model.
module tb_mp_final_reduce;
   import mp_final_reduce_pkg::*;

   logic            clk = 1'b0;
   logic            resetn;
   logic            start;
   logic [OP_W:0]   in_t;
   logic [OP_W-1:0] in_m;
   logic [OP_W-1:0] result;
   logic            reduced;
   logic            busy;
   logic            done;

   int n_tests = 0;
   int n_fail  = 0;

   mp_final_reduce dut (
      .clk     (clk),
      .resetn  (resetn),
      .start   (start),
      .in_t    (in_t),
      .in_m    (in_m),
      .result  (result),
      .reduced (reduced),
      .busy    (busy),
      .done    (done)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [OP_W:0] rand_wide();
      logic [OP_W:0] v = '0;
      for (int i = 0; i < 33; i++) v = (v << 32) | {{(OP_W + 1 - 32){1'b0}}, $urandom()};
      return v;
   endfunction

   // Reference: one conditional subtraction of M from T, result truncated to OP_W bits.
   function automatic void ref_reduce(input logic [OP_W:0] t, input logic [OP_W-1:0] m,
                                      output logic [OP_W-1:0] res, output logic red);
      logic [OP_W:0] diff;
      red  = (t >= {1'b0, m});
      diff = t - {1'b0, m};
      res  = red ? diff[OP_W-1:0] : t[OP_W-1:0];
   endfunction

   // Runs one operation; poke_at > 0 pulses start with junk operands at that cycle.
   task automatic run_op(input string name, input logic [OP_W:0] t, input logic [OP_W-1:0] m,
                         input logic [OP_W-1:0] exp_res, input logic exp_red, input int poke_at);
      int              lat;
      logic [OP_W-1:0] held;
      @(negedge clk);
      start = 1'b1; in_t = t; in_m = m;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0; in_t = rand_wide(); in_m = OP_W'(rand_wide());
      lat = 0;
      for (int k = 1; k <= 12; k++) begin
         @(posedge clk);
         @(negedge clk);
         if (k == 1) begin
            n_tests++;
            if (busy !== 1'b1) begin
               n_fail++;
               $display("FAIL %s busy_after_start: got %b expected 1", name, busy);
            end
         end
         start = (k == poke_at);
         if (start) begin in_t = rand_wide(); in_m = OP_W'(rand_wide()); end
         if (done === 1'b1) begin lat = k; break; end
      end
      start = 1'b0;
      n_tests++;
      if (lat !== 5) begin
         n_fail++;
         $display("FAIL %s latency: got %0d cycles expected 5 (0 = timeout)", name, lat);
      end
      n_tests++;
      if (result !== exp_res) begin
         n_fail++;
         $display("FAIL %s result[127:0]: got %h expected %h", name, result[127:0], exp_res[127:0]);
      end
      n_tests++;
      if (reduced !== exp_red) begin
         n_fail++;
         $display("FAIL %s reduced: got %b expected %b", name, reduced, exp_red);
      end
      held = result;
      @(posedge clk);
      @(negedge clk);
      n_tests++;
      if (done !== 1'b0 || busy !== 1'b0 || result !== exp_res) begin
         n_fail++;
         $display("FAIL %s after_done: done=%b busy=%b result_held=%b expected 0 0 1",
                  name, done, busy, result === held && held === exp_res);
      end
   endtask

   task automatic test_reset();
      resetn = 1'b0; start = 1'b0; in_t = '0; in_m = '0;
      #1;
      n_tests++;
      if (result !== '0 || reduced !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_outputs: got result!=0:%b reduced=%b done=%b busy=%b expected all 0",
                  result !== '0, reduced, done, busy);
      end
      repeat (2) @(negedge clk);
      resetn = 1'b1;
   endtask

   task automatic test_directed();
      logic [OP_W:0]   t;
      logic [OP_W-1:0] m, e;
      t = '0; t[1026] = 1'b1; t[0] = 1'b1;
      m = t[OP_W-1:0];
      run_op("t_eq_m", t, m, '0, 1'b1, 0);
      m = '0; m[1026] = 1'b1; m[2] = 1'b1; m[0] = 1'b1;
      t = {1'b0, m} - 1;
      e = m - 1;
      run_op("t_m_minus_1", t, m, e, 1'b0, 0);
      t = '0; t[OP_W] = 1'b1;
      m = '1;
      e = '0; e[0] = 1'b1;
      run_op("full_borrow_ripple", t, m, e, 1'b1, 0);
      t = '0; m = '0; m[0] = 1'b1;
      run_op("zero_t", t, m, '0, 1'b0, 0);
   endtask

   task automatic test_start_ignored();
      logic [OP_W:0]   t;
      logic [OP_W-1:0] m, e;
      logic            r;
      t = 1000; m = 999;
      run_op("start_in_sub", t, m, 1, 1'b1, 1);
      m = OP_W'(rand_wide()); m[OP_W-1] = 1'b1;
      t = rand_wide() % {m, 1'b0};
      ref_reduce(t, m, e, r);
      run_op("start_in_sel", t, m, e, r, 4);
   endtask

   task automatic test_random();
      logic [OP_W:0]   t;
      logic [OP_W-1:0] m, e;
      logic            r;
      for (int i = 0; i < 20; i++) begin
         m = OP_W'(rand_wide());
         if ($urandom_range(0, 1) == 1) m[OP_W-1] = 1'b1;
         if (m == '0) m = 1;
         case ($urandom_range(0, 3))
            0:       t = {1'b0, m};
            1:       t = {1'b0, m} - 1;
            default: t = rand_wide() % {m, 1'b0};
         endcase
         ref_reduce(t, m, e, r);
         run_op($sformatf("random_%0d", i), t, m, e, r, 0);
      end
   endtask

   task automatic test_async_reset();
      logic [OP_W:0] t;
      logic          saw_done;
      run_op("pre_reset_op", 7, 9, 7, 1'b0, 0);
      t = rand_wide();
      @(negedge clk);
      start = 1'b1; in_t = t; in_m = OP_W'(t >> 1);
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #2;
      n_tests++;
      if (busy !== 1'b1) begin
         n_fail++;
         $display("FAIL busy_before_reset: got %b expected 1", busy);
      end
      resetn = 1'b0;
      #1;
      n_tests++;
      if (result !== '0 || reduced !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL async_reset: got result!=0:%b reduced=%b done=%b busy=%b expected all 0",
                  result !== '0, reduced, done, busy);
      end
      saw_done = 1'b0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if (k == 2) resetn = 1'b1;
         if (done === 1'b1) saw_done = 1'b1;
      end
      n_tests++;
      if (saw_done !== 1'b0) begin
         n_fail++;
         $display("FAIL aborted_no_done: got done pulse %b expected 0", saw_done);
      end
      run_op("after_reset", 5, 3, 2, 1'b1, 0);
   endtask

   task automatic test_back_to_back();
      logic [OP_W:0]   t;
      logic [OP_W-1:0] m, e;
      logic            r;
      int              lat1, gap;
      t = 12345; m = 1000;
      ref_reduce(t, m, e, r);
      @(negedge clk);
      start = 1'b1; in_t = t; in_m = m;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      lat1 = 0;
      for (int k = 1; k <= 12; k++) begin
         @(posedge clk);
         @(negedge clk);
         if (done === 1'b1) begin lat1 = k; break; end
      end
      n_tests++;
      if (lat1 !== 5 || result !== e || reduced !== r) begin
         n_fail++;
         $display("FAIL b2b_first: got lat=%0d result[31:0]=%h reduced=%b expected 5 %h %b",
                  lat1, result[31:0], reduced, e[31:0], r);
      end
      start = 1'b1; in_t = 7; in_m = 9;
      gap = 0;
      for (int k = 1; k <= 12; k++) begin
         @(posedge clk);
         @(negedge clk);
         if (k == 1) begin
            start = 1'b0;
            n_tests++;
            if (busy !== 1'b1) begin
               n_fail++;
               $display("FAIL b2b_reload_busy: got %b expected 1", busy);
            end
         end
         if (done === 1'b1) begin gap = k; break; end
      end
      start = 1'b0;
      n_tests++;
      if (gap !== 6) begin
         n_fail++;
         $display("FAIL b2b_gap: got %0d cycles expected 6 (0 = timeout)", gap);
      end
      n_tests++;
      if (result !== 7 || reduced !== 1'b0) begin
         n_fail++;
         $display("FAIL b2b_second: got result[31:0]=%h reduced=%b expected 00000007 0",
                  result[31:0], reduced);
      end
      @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_directed();
      test_start_ignored();
      test_random();
      test_async_reset();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
